carregador_imem: RTL and testbench
==================================

Name: carregador_imem

Overview:
Boot-time writer for the instruction memory that the MIPS datapath's PC reads from. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them at byte addresses. The byte addresses match the PC's +4 stepping. While loading it holds the core (`cpu_hold`); it releases the core only after a verified checksum.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first written word (same addressing as the PC).
- MAX_WORDS, 256, largest accepted word count; must be ≤ 65535.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_valid  input  1  source has a byte on byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  one-cycle instruction-memory write strobe
- imem_addr  output  32  write byte address
- imem_wdata  output  32  assembled word
- cpu_hold  output  1  keeps PC/core in reset while high
- done  output  1  load completed, checksum good
- error  output  1  load rejected (bad count or checksum)
- words_written  output  16  words written in the current load

Behaviour:
- Frame format, in order:
  - count, high byte
  - count, low byte
  - N×4 data bytes, MSB first per word
  - checksum byte = XOR of all preceding frame bytes (header included)
- Byte transfer occurs only on the rising edge where byte_valid && byte_ready.
- Reset (reset=0, asynchronous), any time including mid-load:
  - state IDLE
  - byte_ready=0, imem_we=0, imem_addr=ADDR_BASE, imem_wdata=0
  - cpu_hold=1, done=0, error=0, words_written=0
  - internal count, byte index and checksum cleared
- States:
  - IDLE: byte_ready=0. start → HDR_HI; clears checksum, words_written and error/done.
  - HDR_HI: byte_ready=1. On transfer: count[15:8] := byte, → HDR_LO.
  - HDR_LO: byte_ready=1. On transfer: count[7:0] := byte.
    - If the full count is 0 or > MAX_WORDS → ERR.
    - Otherwise → DATA, byte index 0.
  - DATA: byte_ready=1. Each transfer shifts the byte into the word register (left shift by 8). On the 4th byte → WRITE.
  - WRITE: exactly one cycle, byte_ready=0.
    - imem_we=1, imem_addr=ADDR_BASE + 4×words_written, imem_wdata=assembled word.
    - Next edge: words_written += 1.
    - If the new value equals count → CHK, else → DATA.
  - CHK: byte_ready=1. On transfer: byte == running XOR → DONE, else → ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → HDR_HI with cpu_hold=1 again (reload).
  - ERR: error=1, cpu_hold=1, byte_ready=0. start → HDR_HI.
- Running XOR updates on every transferred frame byte except the checksum byte itself.
- Outputs are registered. imem_we is high only in WRITE. imem_addr/imem_wdata hold their last values outside WRITE.
- Write latency: the 4th byte of a word is transferred at edge k; imem_we is high during cycle k+1.
- byte_valid with no start is ignored (byte_ready=0); no byte is consumed.
- start pulses in HDR_HI/HDR_LO/DATA/WRITE/CHK are ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32 (no overflow flag). words_written is 16-bit and never exceeds MAX_WORDS.
- byte_valid may drop mid-frame; the loader waits indefinitely in its current state. There is no timeout.

Decomposition:
- Shared package (e.g. mips_pkg): state encoding localparams (IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR), the default ADDR_BASE, and the byte-lane width constant.
- One natural sub-module, `montador_palavra`: 4-byte big-endian shift register with a 2-bit lane counter and a word_full pulse. It is cleared by the FSM on HDR_LO→DATA and on WRITE.
- The FSM, checksum and address generation stay in carregador_imem.

Test Plan:
- Good load: start; stream 00 02 20 08 00 05 AC 08 00 00 8B.
  - Expect imem_we pulses carrying (0x0, 0x20080005) then (0x4, 0xAC080000).
  - Then done=1, cpu_hold=0, words_written=2.
- Bad checksum: same frame with last byte 0x8A → no change to the two writes; error=1, cpu_hold=1, done=0.
- Bad count:
  - Header 00 00 → ERR immediately with zero imem_we pulses.
  - Header 01 01 (257 > MAX_WORDS) → ERR.
- Stalled source: good frame with byte_valid deasserted for 5 cycles between every byte.
  - Identical writes and checksum result.
  - byte_ready=0 in every WRITE cycle.
- Reset mid-load: assert reset=0 after the 6th byte.
  - All outputs immediately return to reset values (cpu_hold=1, imem_we=0).
  - A fresh start and full good frame then load correctly from ADDR_BASE.
- Reload: after DONE, pulse start and send a 1-word frame 00 01 12 34 56 78 0x09.
  - cpu_hold rises on start.
  - Single write (0x0, 0x12345678), then done=1 again.

Source files
------------

// File: rtl/carregador_imem_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package carregador_imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h0000_0000;
    localparam int          MAX_WORDS_DEFAULT = 256;
    localparam int          LANE_W            = 8;

endpackage

// File: rtl/montador_palavra.sv
// Big-endian word assembler: each shifted byte enters at the LSB lane,
// so the first byte of a word ends up in bits [31:24].
module montador_palavra
    import carregador_imem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [LANE_W-1:0] byte_in,
    output logic [31:0]       word_next,
    output logic              word_full
);

    logic [31:0] acc;
    logic [1:0]  lane;

    // word_next is the value the word holds after the current shift, so the
    // caller can latch a complete word on the same edge as its 4th byte.
    assign word_next = {acc[31-LANE_W:0], byte_in};
    assign word_full = shift_en && (lane == 2'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            lane <= '0;
        end else if (clear) begin
            acc  <= '0;
            lane <= '0;
        end else if (shift_en) begin
            acc  <= word_next;
            lane <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/carregador_imem.sv
// Framed byte-stream loader for the MIPS instruction memory; holds the core
// until a frame with a matching XOR checksum has been written.
module carregador_imem
    import carregador_imem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int          MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written,
    output state_t      dbg_state
);

    // Handshake: a byte moves on a rising edge only when byte_valid and
    // byte_ready are both high; byte_ready is registered and depends on state only.
    state_t      state;
    logic [15:0] count;
    logic [7:0]  csum;
    logic        xfer;
    logic [15:0] hdr_count;
    logic [15:0] ww_next;
    logic        asm_clear;
    logic        asm_shift;
    logic [31:0] word_next;
    logic        word_full;

    assign xfer      = byte_valid && byte_ready;
    assign hdr_count = {count[15:8], byte_data};
    assign ww_next   = words_written + 16'd1;
    assign asm_clear = (state == ST_WRITE) || ((state == ST_HDR_LO) && xfer);
    assign asm_shift = (state == ST_DATA) && xfer;
    assign dbg_state = state;

    montador_palavra u_montador (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            csum          <= '0;
            words_written <= '0;
            byte_ready    <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= ADDR_BASE;
            imem_wdata    <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state         <= ST_HDR_HI;
                        byte_ready    <= 1'b1;
                        csum          <= '0;
                        words_written <= '0;
                        cpu_hold      <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                    end
                end
                ST_HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= byte_data;
                        csum        <= csum ^ byte_data;
                        state       <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= byte_data;
                        csum       <= csum ^ byte_data;
                        if (hdr_count == 16'd0 || hdr_count > 16'(MAX_WORDS)) begin
                            state      <= ST_ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ byte_data;
                        if (word_full) begin
                            state      <= ST_WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_BASE + {14'd0, words_written, 2'b00};
                            imem_wdata <= word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    words_written <= ww_next;
                    byte_ready    <= 1'b1;
                    state         <= (ww_next == count) ? ST_CHK : ST_DATA;
                end
                ST_CHK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_imem.sv
// Bench for carregador_imem: directed and random frames checked against a
// frame-level reference model with a write scoreboard.
module tb_carregador_imem;
    import carregador_imem_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_written;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frame[$];
    int          n_send;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_ww;

    carregador_imem dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written),
        .dbg_state     (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected (addr, data).
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            check("we_ready_low", {63'd0, byte_ready}, 64'd0);
            check("we_state", {61'd0, dbg_state}, {61'd0, ST_WRITE});
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 64'd0 - 64'd1);
            end else begin
                check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Reference model: interprets the frame from its definition.
    task automatic model();
        int cnt;
        logic [7:0] x;
        cnt = {frame[0], frame[1]};
        exp_q.delete();
        if (cnt == 0 || cnt > 256) begin
            n_send   = 2;
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_ww   = 16'd0;
        end else begin
            n_send = 2 + 4 * cnt + 1;
            for (int w = 0; w < cnt; w++)
                exp_q.push_back({32'(4 * w), frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
            x = 8'h00;
            for (int i = 0; i < n_send - 1; i++) x = x ^ frame[i];
            exp_done = (x == frame[n_send-1]);
            exp_err  = !exp_done;
            exp_ww   = 16'(cnt);
        end
    endtask

    task automatic make_frame(input int cnt, input bit corrupt);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'(cnt >> 8));
        frame.push_back(8'(cnt));
        for (int i = 0; i < 4 * cnt; i++) frame.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        check("start_hold", {63'd0, cpu_hold}, 64'd1);
        check("start_done", {62'd0, done, error}, 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (byte_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input int gap, input bit mid_start);
        model();
        do_start();
        for (int i = 0; i < n_send; i++) begin
            send_byte(frame[i], gap);
            if (mid_start && i == 3) begin
                start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end
        end
        repeat (2) @(negedge clock);
        check("done", {63'd0, done}, {63'd0, exp_done});
        check("error", {63'd0, error}, {63'd0, exp_err});
        check("cpu_hold", {63'd0, cpu_hold}, {63'd0, !exp_done});
        check("words_written", {48'd0, words_written}, {48'd0, exp_ww});
        check("ready_idle", {63'd0, byte_ready}, 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
        check({tag, "_we"}, {63'd0, imem_we}, 64'd0);
        check({tag, "_addr_data"}, {imem_addr, imem_wdata}, 64'd0);
        check({tag, "_flags"}, {61'd0, cpu_hold, done, error}, 64'd4);
        check({tag, "_ww"}, {48'd0, words_written}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        @(posedge clock);
        #1 reset = 1'b1;

        // Bytes offered without a start must be ignored.
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (4) begin
            @(negedge clock);
            check("idle_ready", {63'd0, byte_ready}, 64'd0);
        end
        @(posedge clock);
        #1 byte_valid = 1'b0;
        check("idle_ww", {48'd0, words_written}, 64'd0);

        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
        run_frame(0, 1'b0);

        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8A};
        run_frame(0, 1'b0);

        frame = '{8'h00, 8'h00};
        run_frame(0, 1'b0);

        frame = '{8'h01, 8'h01};
        run_frame(0, 1'b0);

        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
        run_frame(5, 1'b1);

        // Reset in the middle of a load, then a clean reload.
        exp_q.delete();
        do_start();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        #1 reset = 1'b0;
        #1 check_reset_values("midreset");
        @(posedge clock);
        #1 reset = 1'b1;
        run_frame(0, 1'b0);

        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run_frame(0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 5) == 0) begin
                frame.delete();
                frame.push_back(8'($urandom_range(1, 255)));
                frame.push_back(8'($urandom_range(0, 255)));
            end else begin
                make_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
            end
            run_frame($urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
